// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM states, grant encodings, default widths.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes and RAM control bus of the arbiter; the tristate data bus is a separate port.
interface mem_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
) ();

    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic              if_ack;
    logic [DWIDTH-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_ack;
    logic [DWIDTH-1:0] d_rdata;

    logic [AWIDTH-1:0] ram_addr;
    logic              ram_rd_en;
    logic              ram_wr_en;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_ack, if_rdata, d_ack, d_rdata, ram_addr, ram_rd_en, ram_wr_en
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_ack, if_rdata, d_ack, d_rdata, ram_addr, ram_rd_en, ram_wr_en
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection. MEM_ARB_ROUND_ROBIN_EN: on contention the port not granted
// last wins; otherwise the data port always wins.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  gnt_t last_gnt,
`endif
    output gnt_t gnt
);

    always_comb begin
        gnt = GNT_IF;
        if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gnt = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
`else
            gnt = GNT_D;
`endif
        end else if (d_req) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-port RAM: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Optional MEM_ARB_ROUND_ROBIN_EN builds a last-grant register for alternating priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    inout  wire  [DWIDTH-1:0] ram_data
);

    state_t            state;
    gnt_t              gnt;
    gnt_t              pick;
    logic              we_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [AWIDTH-1:0] addr_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [DWIDTH-1:0] if_rdata_q;
    logic [DWIDTH-1:0] d_rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    gnt_t last_gnt;

    mem_arb_pick u_pick (
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );
`else
    mem_arb_pick u_pick (
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .gnt    (pick)
    );
`endif

    // The arbiter only owns the bus while a write is in flight.
    assign ram_data = wr_en_q ? wdata_q : {DWIDTH{1'bz}};

    assign bus.ram_addr  = addr_q;
    assign bus.ram_rd_en = rd_en_q;
    assign bus.ram_wr_en = wr_en_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gnt        <= GNT_IF;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_gnt   <= GNT_IF;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    if (bus.if_req || bus.d_req) begin
                        gnt   <= pick;
                        state <= ACCESS;
                        if (pick == GNT_D) begin
                            addr_q  <= bus.d_addr;
                            we_q    <= bus.d_we;
                            wdata_q <= bus.d_wdata;
                            rd_en_q <= !bus.d_we;
                            wr_en_q <= bus.d_we;
                        end else begin
                            addr_q  <= bus.if_addr;
                            we_q    <= 1'b0;
                            rd_en_q <= 1'b1;
                            wr_en_q <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // RAM read is combinational, so data is valid at this closing edge.
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    if (gnt == GNT_D) begin
                        d_ack_q <= 1'b1;
                        if (!we_q) d_rdata_q <= ram_data;
                    end else begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= ram_data;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_gnt <= gnt;
`endif
                    state <= DONE;
                end
                DONE: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    rd_en_q  <= 1'b0;
                    wr_en_q  <= 1'b0;
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM on the tristate bus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    wire  [31:0] ram_data;
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    int          checks = 0;
    int          errors = 0;

    mem_arbiter_if #(.DWIDTH(32), .AWIDTH(8)) bus ();

    mem_arbiter #(.DWIDTH(32), .AWIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    assign ram_data = bus.ram_rd_en ? mem[bus.ram_addr] : 32'hzzzz_zzzz;
    always @(posedge clk) if (bus.ram_wr_en) mem[bus.ram_addr] <= ram_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        reset = 1'b0;
        step(); step();
        checks++;
        if ({bus.if_ack, bus.d_ack, bus.ram_rd_en, bus.ram_wr_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl got %b want 0000", {bus.if_ack, bus.d_ack, bus.ram_rd_en, bus.ram_wr_en});
        end
        checks++;
        if (bus.ram_addr !== 8'h00) begin
            errors++; $display("FAIL reset_addr got %h want 00", bus.ram_addr);
        end
        checks++;
        if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h want 0/0", bus.if_rdata, bus.d_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        bit saw_d = 0;
        bus.if_req = 1; bus.if_addr = 8'd5;
        step();
        checks++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_wr_en !== 1'b0 || bus.ram_addr !== 8'd5) begin
            errors++; $display("FAIL fetch_access rd=%b wr=%b addr=%h want 1 0 05", bus.ram_rd_en, bus.ram_wr_en, bus.ram_addr);
        end
        checks++;
        if (bus.if_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_early_ack got %b want 0", bus.if_ack);
        end
        step();
        checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h60DF0081) begin
            errors++; $display("FAIL fetch_ack ack=%b data=%h want 1 60df0081", bus.if_ack, bus.if_rdata);
        end
        checks++;
        if (bus.ram_rd_en !== 1'b0 || bus.ram_wr_en !== 1'b0) begin
            errors++; $display("FAIL fetch_done_en rd=%b wr=%b want 0 0", bus.ram_rd_en, bus.ram_wr_en);
        end
        bus.if_req = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.d_ack) saw_d = 1;
            step();
        end
        checks++;
        if (bus.if_ack !== 1'b0 || saw_d) begin
            errors++; $display("FAIL fetch_after if_ack=%b saw_d_ack=%b want 0 0", bus.if_ack, saw_d);
        end
    endtask

    task automatic test_store_load();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h10; bus.d_wdata = 32'hDEADBEEF;
        step();
        checks++;
        if (bus.ram_wr_en !== 1'b1 || bus.ram_rd_en !== 1'b0 || ram_data !== 32'hDEADBEEF || bus.ram_addr !== 8'h10) begin
            errors++; $display("FAIL store_access wr=%b rd=%b data=%h addr=%h want 1 0 deadbeef 10",
                               bus.ram_wr_en, bus.ram_rd_en, ram_data, bus.ram_addr);
        end
        bus.d_wdata = 32'h0; bus.d_addr = 8'h11;
        step();
        checks++;
        if (bus.d_ack !== 1'b1 || bus.ram_wr_en !== 1'b0) begin
            errors++; $display("FAIL store_ack ack=%b wr=%b want 1 0", bus.d_ack, bus.ram_wr_en);
        end
        checks++;
        if (bus.d_rdata !== 32'h0 || bus.if_rdata !== 32'h60DF0081) begin
            errors++; $display("FAIL store_no_rdata d=%h if=%h want 0 60df0081", bus.d_rdata, bus.if_rdata);
        end
        bus.d_req = 0;
        step(); step();
        checks++;
        if (mem[8'h10] !== 32'hDEADBEEF || mem[8'h11] !== shadow[8'h11]) begin
            errors++; $display("FAIL store_ram got %h/%h want deadbeef/%h", mem[8'h10], mem[8'h11], shadow[8'h11]);
        end
        shadow[8'h10] = 32'hDEADBEEF;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h10;
        step();
        checks++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_wr_en !== 1'b0) begin
            errors++; $display("FAIL load_access rd=%b wr=%b want 1 0", bus.ram_rd_en, bus.ram_wr_en);
        end
        step();
        checks++;
        if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_ack ack=%b data=%h want 1 deadbeef", bus.d_ack, bus.d_rdata);
        end
        bus.d_req = 0;
        step(); step();
    endtask

    task automatic test_contention();
        int d_cyc = -1;
        int i_cyc = -1;
        do_reset();
        bus.if_req = 1; bus.if_addr = 8'd1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'd2;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (bus.d_ack && d_cyc < 0) begin d_cyc = c; bus.d_req = 0; end
            if (bus.if_ack && i_cyc < 0) begin i_cyc = c; bus.if_req = 0; end
        end
        checks++;
        if (d_cyc != 2 || i_cyc != 5) begin
            errors++; $display("FAIL contention_order d_ack@%0d if_ack@%0d want 2 5", d_cyc, i_cyc);
        end
        checks++;
        if (bus.d_rdata !== 32'h22222222 || bus.if_rdata !== 32'h11111111) begin
            errors++; $display("FAIL contention_data d=%h if=%h want 22222222 11111111", bus.d_rdata, bus.if_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq = 4'b0000;
        logic [3:0] exp_seq;
        int n = 0;
        bit both = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        do_reset();
        bus.if_req = 1; bus.if_addr = 8'd1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'd2;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.if_ack && bus.d_ack) both = 1;
            if ((bus.if_ack || bus.d_ack) && n < 4) begin
                seq[n] = bus.d_ack;
                n++;
            end
        end
        bus.if_req = 0; bus.d_req = 0;
        checks++;
        if (n != 4 || seq !== exp_seq || both) begin
            errors++; $display("FAIL rr_order acks=%0d seq=%b both=%b want 4 %b 0", n, seq, both, exp_seq);
        end
        step(); step(); step();
    endtask

    task automatic test_reset_mid_access();
        bit saw_d = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h20; bus.d_wdata = 32'h12345678;
        step();
        checks++;
        if (bus.ram_wr_en !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre wr=%b want 1", bus.ram_wr_en);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.ram_rd_en, bus.ram_wr_en, bus.d_ack, bus.if_ack} !== 4'b0000 || bus.ram_addr !== 8'h00) begin
            errors++; $display("FAIL rst_mid_async ctl=%b addr=%h want 0000 00",
                               {bus.ram_rd_en, bus.ram_wr_en, bus.d_ack, bus.if_ack}, bus.ram_addr);
        end
        checks++;
        if (bus.d_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_rdata d=%h if=%h want 0 0", bus.d_rdata, bus.if_rdata);
        end
        bus.d_req = 0;
        bus.if_req = 1; bus.if_addr = 8'd5;
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 8'd5) begin
            errors++; $display("FAIL rst_mid_resume rd=%b addr=%h want 1 05", bus.ram_rd_en, bus.ram_addr);
        end
        step();
        if (bus.d_ack) saw_d = 1;
        checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h60DF0081 || saw_d) begin
            errors++; $display("FAIL rst_mid_fetch ack=%b data=%h d_ack=%b want 1 60df0081 0", bus.if_ack, bus.if_rdata, saw_d);
        end
        bus.if_req = 0;
        step(); step();
        mem[8'h20] = shadow[8'h20];
    endtask

    task automatic test_random();
        for (int it = 0; it < 1000; it++) begin
            int          op;
            bit          want_if, want_d, dwe, viol;
            int          n_if, n_d;
            bit          bad_if_data, bad_d_data;
            logic [31:0] wd;
            logic [7:0]  ia, da;
            op = $urandom_range(0, 3);
            want_if = (op == 0) || (op == 3);
            want_d  = (op != 0);
            dwe = (op == 2) ? 1'b1 : ((op == 3) ? 1'($urandom_range(0, 1)) : 1'b0);
            ia = 8'($urandom_range(0, 255));
            da = 8'($urandom_range(0, 255));
            wd = $urandom;
            viol = 0; n_if = 0; n_d = 0; bad_if_data = 0; bad_d_data = 0;
            bus.if_req = want_if; bus.if_addr = ia;
            bus.d_req = want_d; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = wd;
            for (int c = 0; c < 12; c++) begin
                step();
                if (bus.ram_rd_en && bus.ram_wr_en) viol = 1;
                if (bus.ram_wr_en && ram_data !== wd) viol = 1;
                if (bus.ram_rd_en && ram_data !== shadow[bus.ram_addr]) viol = 1;
                if (bus.if_ack) begin
                    n_if++;
                    bus.if_req = 0;
                    if (bus.if_rdata !== shadow[ia]) bad_if_data = 1;
                end
                if (bus.d_ack) begin
                    n_d++;
                    bus.d_req = 0;
                    if (dwe) shadow[da] = wd;
                    else if (bus.d_rdata !== shadow[da]) bad_d_data = 1;
                end
                if (!bus.if_req && !bus.d_req && c >= 2) break;
            end
            bus.if_req = 0; bus.d_req = 0;
            checks++;
            if (viol) begin
                errors++; $display("FAIL rand_bus it=%0d violation=%b want 0", it, viol);
            end
            checks++;
            if (n_if != int'(want_if) || n_d != int'(want_d)) begin
                errors++; $display("FAIL rand_acks it=%0d if=%0d d=%0d want %0d %0d", it, n_if, n_d, want_if, want_d);
            end
            checks++;
            if (bad_if_data || bad_d_data) begin
                errors++; $display("FAIL rand_data it=%0d bad_if=%b bad_d=%b want 0 0", it, bad_if_data, bad_d_data);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {24'hA5C300, 8'(i)} ^ 32'h0F0F_0000;
        end
        mem[5] = 32'h60DF0081;
        mem[1] = 32'h11111111;
        mem[2] = 32'h22222222;
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_round_robin();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
